pcm_frame_muter: RTL and testbench



---
 rtl/pcm_mute_pkg.sv | 19 +
 rtl/pcm_mute_sync2.sv | 29 ++
 rtl/pcm_frame_muter.sv | 151 +++++++++++++++
 tb/tb_pcm_frame_muter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_mute_pkg.sv
// Shared types and default constants for the PCM frame muter and its
// clock-exchanger companions.
package pcm_mute_pkg;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_MUTE_PEND = 2'd1,
    ST_MUTED     = 2'd2,
    ST_REL_PEND  = 2'd3
  } mute_state_e;

  localparam int unsigned RELEASE_FRAMES_DEF = 16;
  localparam int unsigned WDOG_LIMIT_DEF     = 128;

  function automatic logic state_is_gated(input mute_state_e s);
    return (s == ST_MUTED) || (s == ST_REL_PEND);
  endfunction

endpackage

// File: rtl/pcm_mute_sync2.sv
// Two-flop synchroniser for a single asynchronous level signal.
module pcm_mute_sync2 (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pcm_frame_muter.sv
// Frame-aligned I2S muter: zeroes whole stereo frames on a mute request.
// Optional LRCK watchdog enabled by defining PCM_MUTE_LRCK_WDOG_EN.
module pcm_frame_muter
  import pcm_mute_pkg::*;
#(
  parameter int unsigned LANES          = 4,
  parameter int unsigned RELEASE_FRAMES = RELEASE_FRAMES_DEF,
  parameter int unsigned WDOG_LIMIT     = WDOG_LIMIT_DEF
) (
  input  logic             bck_i,
  input  logic             nrst_i,
  input  logic             lrck_i,
  input  logic [LANES-1:0] sdata_i,
  input  logic             ndatmute_i,
  output logic             lrck_o,
  output logic [LANES-1:0] sdata_o,
  output logic             nmute_o,
  output logic             lrck_lost_o
);

  if (RELEASE_FRAMES < 1 || RELEASE_FRAMES > 255) begin : g_bad_release
    $error("RELEASE_FRAMES must be within 1..255");
  end
  if (WDOG_LIMIT < 1) begin : g_bad_wdog
    $error("WDOG_LIMIT must be at least 1");
  end

  localparam logic [7:0] REL_LAST = 8'(RELEASE_FRAMES - 1);

  logic             ndatmute_sync;
  logic             mute_req;
  logic             frame_start;
  logic             lrck_lost;
  logic             gate_d;

  mute_state_e      state_q, state_d;
  logic [7:0]       rel_cnt_q, rel_cnt_d;
  logic             lrck_q, lrck_d;
  logic [LANES-1:0] sdata_q, sdata_d;
  logic             nmute_q, nmute_d;

  pcm_mute_sync2 u_sync (
    .clk_i  (bck_i),
    .nrst_i (nrst_i),
    .d_i    (ndatmute_i),
    .q_o    (ndatmute_sync)
  );

`ifdef PCM_MUTE_LRCK_WDOG_EN
  localparam int unsigned       WDOG_W   = $clog2(WDOG_LIMIT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

  logic              lrck_edge;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              lrck_lost_q, lrck_lost_d;

  always_comb begin
    lrck_edge = lrck_q ^ lrck_i;
    wdog_d    = wdog_q;
    if (lrck_edge) begin
      wdog_d = '0;
    end else if (wdog_q != WDOG_MAX) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    lrck_lost_d = !lrck_edge && (wdog_d == WDOG_MAX);
  end

  always_ff @(posedge bck_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wdog_q      <= '0;
      lrck_lost_q <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      lrck_lost_q <= lrck_lost_d;
    end
  end

  assign lrck_lost = lrck_lost_q;
`else
  assign lrck_lost = 1'b0;
`endif

  assign mute_req    = ~ndatmute_sync | lrck_lost;
  assign frame_start = lrck_q & ~lrck_i;

  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    unique case (state_q)
      ST_PLAY: begin
        if (mute_req) state_d = ST_MUTE_PEND;
      end
      ST_MUTE_PEND: begin
        if (!mute_req) begin
          state_d = ST_PLAY;
        end else if (frame_start) begin
          state_d   = ST_MUTED;
          rel_cnt_d = '0;
        end
      end
      ST_MUTED: begin
        if (!mute_req) begin
          state_d   = ST_REL_PEND;
          rel_cnt_d = '0;
        end
      end
      ST_REL_PEND: begin
        if (mute_req) begin
          state_d   = ST_MUTED;
          rel_cnt_d = '0;
        end else if (frame_start) begin
          if (rel_cnt_q == REL_LAST) begin
            state_d = ST_PLAY;
          end else if (rel_cnt_q != '1) begin
            rel_cnt_d = rel_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_MUTED;
    endcase

    // Gate from the next state so the data sampled on the deciding
    // frame_start is already on the new side of the boundary.
    gate_d  = state_is_gated(state_d);
    lrck_d  = lrck_i;
    sdata_d = gate_d ? '0 : sdata_i;
    nmute_d = ~gate_d;
  end

  always_ff @(posedge bck_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= ST_MUTED;
      rel_cnt_q <= '0;
      lrck_q    <= 1'b0;
      sdata_q   <= '0;
      nmute_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rel_cnt_q <= rel_cnt_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      nmute_q   <= nmute_d;
    end
  end

  assign lrck_o      = lrck_q;
  assign sdata_o     = sdata_q;
  assign nmute_o     = nmute_q;
  assign lrck_lost_o = lrck_lost;

endmodule

// File: tb/tb_pcm_frame_muter.sv
// Self-checking bench for pcm_frame_muter: 64-bck frames, phase table plus
// per-cycle scoreboard, with directed async-reset checks.
module tb_pcm_frame_muter;

  localparam int unsigned LANES = 4;
  localparam int unsigned REL   = 4;
  localparam int unsigned WDOG  = 128;

  logic             bck_i = 1'b0;
  logic             nrst_i;
  logic             lrck_i;
  logic [LANES-1:0] sdata_i;
  logic             ndatmute_i;
  logic             lrck_o;
  logic [LANES-1:0] sdata_o;
  logic             nmute_o;
  logic             lrck_lost_o;

  always #5 bck_i = ~bck_i;

  pcm_frame_muter #(
    .LANES          (LANES),
    .RELEASE_FRAMES (REL),
    .WDOG_LIMIT     (WDOG)
  ) dut (
    .bck_i       (bck_i),
    .nrst_i      (nrst_i),
    .lrck_i      (lrck_i),
    .sdata_i     (sdata_i),
    .ndatmute_i  (ndatmute_i),
    .lrck_o      (lrck_o),
    .sdata_o     (sdata_o),
    .nmute_o     (nmute_o),
    .lrck_lost_o (lrck_lost_o)
  );

  typedef struct packed {
    logic [LANES-1:0] sdata;
    logic             nmute;
    logic             lrck;
    logic             lost;
  } exp_t;

  typedef struct {
    string name;
    int    cycles;
    bit    ndat;
    bit    run;
    bit    data_f;
    bit    exp_nmute;
    bit    exp_lost;
  } phase_t;

  exp_t   sb_q[$];
  phase_t phases[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  int pos;
  bit run_lrck;
  bit force_f;

  // reference model state (0 play, 1 mute pending, 2 muted, 3 release pending)
  bit m_lrck, m_s1, m_s2, m_lost;
  int m_state, m_rel, m_wd;

  task automatic model_reset();
    m_lrck = 0; m_s1 = 0; m_s2 = 0; m_lost = 0;
    m_state = 2; m_rel = 0; m_wd = 0;
    sb_q.delete();
  endtask

  task automatic model_step();
    bit   fs, edge_seen, mreq, gate;
    int   ns, nr, nwd;
    exp_t e;
    fs        = m_lrck && !lrck_i;
    edge_seen = (m_lrck != lrck_i);
    mreq      = !m_s2 || m_lost;
    ns = m_state;
    nr = m_rel;
    case (m_state)
      0: if (mreq) ns = 1;
      1: if (!mreq) ns = 0; else if (fs) begin ns = 2; nr = 0; end
      2: if (!mreq) begin ns = 3; nr = 0; end
      default: begin
        if (mreq) begin ns = 2; nr = 0; end
        else if (fs) begin
          if (m_rel == REL - 1) ns = 0;
          else nr = m_rel + 1;
        end
      end
    endcase
    gate    = (ns >= 2);
    e.sdata = gate ? '0 : sdata_i;
    e.nmute = !gate;
    e.lrck  = lrck_i;
`ifdef PCM_MUTE_LRCK_WDOG_EN
    nwd    = edge_seen ? 0 : ((m_wd + 1 > WDOG) ? WDOG : m_wd + 1);
    m_lost = !edge_seen && (nwd == WDOG);
    m_wd   = nwd;
`else
    nwd = edge_seen ? 0 : m_wd;
    m_wd = nwd;
`endif
    e.lost  = m_lost;
    sb_q.push_back(e);
    m_state = ns;
    m_rel   = nr;
    m_s2    = m_s1;
    m_s1    = ndatmute_i;
    m_lrck  = lrck_i;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic tick(input bit ndat);
    exp_t e;
    @(negedge bck_i);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++;
      if ({sdata_o, nmute_o, lrck_o, lrck_lost_o} !== e) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got sdata=%h nmute=%b lrck=%b lost=%b, expected sdata=%h nmute=%b lrck=%b lost=%b",
                 $time, sdata_o, nmute_o, lrck_o, lrck_lost_o, e.sdata, e.nmute, e.lrck, e.lost);
      end
    end
    ndatmute_i = ndat;
    lrck_i     = (pos >= 32);
    sdata_i    = force_f ? '1 : LANES'($urandom);
    model_step();
    if (run_lrck) pos = (pos + 1) % 64;
  endtask

  task automatic run_phase(input phase_t ph);
    run_lrck = ph.run;
    force_f  = ph.data_f;
    repeat (ph.cycles) tick(ph.ndat);
    @(posedge bck_i);
    #1;
    check({ph.name, ".nmute"}, 32'(nmute_o), 32'(ph.exp_nmute));
    check({ph.name, ".lost"}, 32'(lrck_lost_o), 32'(ph.exp_lost));
  endtask

  task automatic add(input string n, input int c, input bit nd, input bit r,
                     input bit f, input bit en, input bit el);
    phase_t p;
    p.name = n; p.cycles = c; p.ndat = nd; p.run = r;
    p.data_f = f; p.exp_nmute = en; p.exp_lost = el;
    phases.push_back(p);
  endtask

  task automatic apply_reset();
    nrst_i = 1'b0;
    lrck_i = 1'b0;
    pos    = 0;
    model_reset();
    repeat (2) @(posedge bck_i);
    #2;
    nrst_i = 1'b1;
  endtask

  initial begin
    //   name          cycles ndat run data_f nmute lost
    add("pwr_3fs",     256, 1, 1, 0, 0, 0);
    add("pwr_4fs",      64, 1, 1, 0, 1, 0);
    add("pre_drop",     10, 1, 1, 0, 1, 0);
    add("drop_b10",     54, 0, 1, 0, 1, 0);
    add("muted",        64, 0, 1, 0, 0, 0);
    add("rel_a",       128, 1, 1, 0, 0, 0);
    add("remute",       64, 0, 1, 0, 0, 0);
    add("rel_b",       192, 1, 1, 0, 0, 0);
    add("rel_c",        64, 1, 1, 0, 0, 0);
    add("rel_d",        64, 1, 1, 0, 1, 0);
    add("pre_glitch",   20, 1, 1, 0, 1, 0);
    add("glitch",        1, 0, 1, 0, 1, 0);
    add("post_glitch", 107, 1, 1, 0, 1, 0);
`ifdef PCM_MUTE_LRCK_WDOG_EN
    add("wd_pre",       40, 1, 1, 0, 1, 0);
    add("wd_hold",     140, 1, 0, 0, 1, 1);
    add("wd_resume",    24, 1, 1, 0, 1, 1);
    add("wd_mute",      64, 1, 1, 0, 0, 0);
    add("wd_rel",      192, 1, 1, 0, 0, 0);
    add("wd_rel4",      64, 1, 1, 0, 1, 0);
`endif
    add("f_data",       40, 1, 1, 1, 1, 0);

    ndatmute_i = 1'b1;
    sdata_i    = '0;
    run_lrck   = 1'b1;
    force_f    = 1'b0;
    nrst_i     = 1'b0;
    lrck_i     = 1'b0;
    pos        = 0;
    model_reset();
    repeat (3) @(negedge bck_i);
    check("rst.sdata", 32'(sdata_o), 32'h0);
    check("rst.nmute", 32'(nmute_o), 32'h0);
    check("rst.lrck",  32'(lrck_o), 32'h0);
    check("rst.lost",  32'(lrck_lost_o), 32'h0);
    @(posedge bck_i);
    #2;
    nrst_i = 1'b1;

    for (int i = 0; i < phases.size(); i++) run_phase(phases[i]);

    // async reset in the middle of a right slot carrying 0xF on every lane
    @(negedge bck_i);
    check("pre_arst.sdata", 32'(sdata_o), 32'hF);
    check("pre_arst.lrck",  32'(lrck_o), 32'h1);
    #2;
    nrst_i = 1'b0;
    #1;
    check("arst.sdata", 32'(sdata_o), 32'h0);
    check("arst.nmute", 32'(nmute_o), 32'h0);
    check("arst.lrck",  32'(lrck_o), 32'h0);
    check("arst.lost",  32'(lrck_lost_o), 32'h0);
    force_f  = 1'b0;
    run_lrck = 1'b1;
    apply_reset();
    begin
      phase_t p;
      p.name = "post_rst_3fs"; p.cycles = 256; p.ndat = 1; p.run = 1;
      p.data_f = 0; p.exp_nmute = 0; p.exp_lost = 0;
      run_phase(p);
      p.name = "post_rst_4fs"; p.cycles = 64; p.exp_nmute = 1;
      run_phase(p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
